// File: rtl/if_id_skid_buffer.sv
// ============================================================================
// Module   : if_id_skid_buffer
// Purpose  : Two-entry IF/ID valid/ready buffer with a skid entry and flush.
//            Define IF_ID_PERF_CNT_EN to add the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_skid_buffer #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_pred_taken,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic            head_pred_q, head_pred_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic            skid_pred_q, skid_pred_d;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from the state flop so fetch pc_en is registered.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_pc         = head_pc_q;
    assign out_instr      = (state_q == ST_EMPTY) ? NOP_INSTR : head_instr_q;
    assign out_pred_taken = (state_q == ST_EMPTY) ? 1'b0 : head_pred_q;

    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        head_pred_d  = head_pred_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pred_d  = skid_pred_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            head_instr_d = NOP_INSTR;
            head_pred_d  = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d      = ST_ONE;
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        head_pred_d  = in_pred_taken;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        head_pred_d  = in_pred_taken;
                    end else if (w_push) begin
                        state_d      = ST_FULL;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                        skid_pred_d  = in_pred_taken;
                    end else if (w_pop) begin
                        state_d      = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        state_d      = ST_ONE;
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                        head_pred_d  = skid_pred_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            head_pc_q    <= '0;
            head_instr_q <= NOP_INSTR;
            head_pred_q  <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pred_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            head_pred_q  <= head_pred_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pred_q  <= skid_pred_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
